// File: rtl/blk_ram_pkg.sv
// Shared types and constants for the byte-enable block RAM.
// The read-during-write selectors, FSM state type and lane-count helper live here.
package blk_ram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int RDW_NO_CHANGE   = 2;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   function automatic int nb(input int dwidth, input int byte_w);
      return dwidth / byte_w;
   endfunction

endpackage

// File: rtl/blk_ram_core.sv
// Bare storage array with per-lane write enables and a registered read port.
// Only the read register is reset; the array itself never is.
module blk_ram_core import blk_ram_pkg::*; #(
   parameter int DWIDTH    = 32,
   parameter int BYTE_W    = 8,
   parameter int AWIDTH    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int RDW_MODE  = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             we,
   input  logic [nb(DWIDTH, BYTE_W)-1:0]    be,
   input  logic [AWIDTH-1:0]                addr,
   input  logic [DWIDTH-1:0]                wdata,
   input  logic                             rd_en,
   input  logic                             rd_zero,
   output logic [DWIDTH-1:0]                rdata
);

   localparam int NB = nb(DWIDTH, BYTE_W);

   logic [DWIDTH-1:0] mem [MEM_DEPTH];
   logic [DWIDTH-1:0] old_word;
   logic [DWIDTH-1:0] merged;

   always_comb begin
      old_word = mem[addr];
      merged   = old_word;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // Out-of-range accesses return zero rather than whatever the array decode yields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (rd_en) begin
         if (rd_zero)                                  rdata <= '0;
         else if (RDW_MODE == RDW_WRITE_FIRST && we)   rdata <= merged;
         else                                          rdata <= old_word;
      end
   end

endmodule

// File: rtl/blk_ram_bw.sv
// Single-port block RAM top: clear engine FSM, port muxing, and the read-valid pipeline.
// Results hold on datao until the next dvalid; busy blocks requests while clearing.
module blk_ram_bw import blk_ram_pkg::*; #(
   parameter int DWIDTH        = 32,
   parameter int BYTE_W        = 8,
   parameter int AWIDTH        = 8,
   parameter int MEM_DEPTH     = 256,
   parameter int RD_LAT        = 1,
   parameter int RDW_MODE      = 0,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             wen,
   input  logic [nb(DWIDTH, BYTE_W)-1:0]    be,
   input  logic [AWIDTH-1:0]                addr,
   input  logic [DWIDTH-1:0]                datai,
   input  logic                             clr,
   output logic [DWIDTH-1:0]                datao,
   output logic                             dvalid,
   output logic                             busy,
   output logic                             err
);

   localparam int                NB        = nb(DWIDTH, BYTE_W);
   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_DEPTH - 1);

   state_t              state, state_nxt;
   logic                init_pend;
   logic [AWIDTH-1:0]   clr_addr, clr_addr_nxt;
   logic                acc, in_range, rd_en, err_req;
   logic                mem_we;
   logic [NB-1:0]       mem_be;
   logic [AWIDTH-1:0]   mem_addr;
   logic [DWIDTH-1:0]   mem_wdata, rdata;
   logic                v1, e1;

   // init_pend keeps busy high during reset and triggers the post-reset clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         clr_addr  <= '0;
         init_pend <= (INIT_ON_RESET != 0);
      end else begin
         state     <= state_nxt;
         clr_addr  <= clr_addr_nxt;
         init_pend <= 1'b0;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      busy         = init_pend || (state == ST_CLEAR);
      case (state)
         ST_IDLE: begin
            if (init_pend || clr) begin
               state_nxt    = ST_CLEAR;
               clr_addr_nxt = '0;
            end
         end
         ST_CLEAR: begin
            clr_addr_nxt = clr_addr + 1'b1;
            if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A clr pulse in the same idle cycle as a request wins and drops the request.
      acc      = en && !busy && !clr;
      in_range = {1'b0, addr} < (AWIDTH + 1)'(MEM_DEPTH);
      rd_en    = acc && (!wen || !in_range || (RDW_MODE != RDW_NO_CHANGE));
      err_req  = acc && !in_range;

      mem_we    = (state == ST_CLEAR) || (acc && wen && in_range);
      mem_addr  = (state == ST_CLEAR) ? clr_addr : addr;
      mem_be    = (state == ST_CLEAR) ? '1 : be;
      mem_wdata = (state == ST_CLEAR) ? '0 : datai;
   end

   blk_ram_core #(
      .DWIDTH   (DWIDTH),
      .BYTE_W   (BYTE_W),
      .AWIDTH   (AWIDTH),
      .MEM_DEPTH(MEM_DEPTH),
      .RDW_MODE (RDW_MODE)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (mem_we),
      .be     (mem_be),
      .addr   (mem_addr),
      .wdata  (mem_wdata),
      .rd_en  (rd_en),
      .rd_zero(!in_range),
      .rdata  (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
      end else begin
         v1 <= rd_en;
         e1 <= err_req;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [DWIDTH-1:0] d2;
      logic              v2, e2;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d2 <= '0;
            v2 <= 1'b0;
            e2 <= 1'b0;
         end else begin
            v2 <= v1;
            e2 <= e1;
            if (v1) d2 <= rdata;
         end
      end

      assign datao  = d2;
      assign dvalid = v2;
      assign err    = e2;
   end else begin : g_lat1
      assign datao  = rdata;
      assign dvalid = v1;
      assign err    = e1;
   end

endmodule

// File: tb/tb_blk_ram_bw.sv
// Bench for blk_ram_bw: five instances share one stimulus stream and differ in
// latency, read-during-write mode and depth; a per-instance model feeds one scoreboard.
module tb_blk_ram_bw;

   localparam int NI = 5;

   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b0;
   logic        wen   = 1'b0;
   logic        clr   = 1'b0;
   logic [3:0]  be    = '0;
   logic [7:0]  addr  = '0;
   logic [31:0] datai = '0;

   logic [31:0] datao_a  [NI];
   logic        dvalid_a [NI];
   logic        busy_a   [NI];
   logic        err_a    [NI];

   int dep  [NI] = '{256, 256, 256, 256, 200};
   int lat  [NI] = '{1, 1, 1, 2, 1};
   int mode [NI] = '{0, 1, 2, 0, 0};

   logic [31:0] ref_m [NI][256];
   exp_t        exp_q [$];
   exp_t        m_e;
   int          m_idx;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      blk_ram_bw #(
         .DWIDTH       (32),
         .BYTE_W       (8),
         .AWIDTH       (8),
         .MEM_DEPTH    (g == 4 ? 200 : 256),
         .RD_LAT       (g == 3 ? 2 : 1),
         .RDW_MODE     (g == 1 ? 1 : (g == 2 ? 2 : 0)),
         .INIT_ON_RESET(1)
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .wen   (wen),
         .be    (be),
         .addr  (addr),
         .datai (datai),
         .clr   (clr),
         .datao (datao_a[g]),
         .dvalid(dvalid_a[g]),
         .busy  (busy_a[g]),
         .err   (err_a[g])
      );
   end

   // ---------------- scoreboard ----------------
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      for (int k = 0; k < NI; k++) begin
         if (dvalid_a[k]) begin
            m_idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
               if (m_idx < 0 && exp_q[i].id == 3'(k)) m_idx = i;
            total++;
            if (m_idx < 0) begin
               bad++;
               $display("FAIL sb_spurious inst=%0d cyc=%0d got data=%h err=%b want no result",
                        k, cyc, datao_a[k], err_a[k]);
            end else begin
               m_e = exp_q[m_idx];
               exp_q.delete(m_idx);
               if (m_e.due !== 32'(cyc) || datao_a[k] !== m_e.data || err_a[k] !== m_e.err) begin
                  bad++;
                  $display("FAIL sb_result inst=%0d cyc=%0d got data=%h err=%b want data=%h err=%b at cyc=%0d",
                           k, cyc, datao_a[k], err_a[k], m_e.data, m_e.err, m_e.due);
               end
            end
         end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (int'(exp_q[i].due) < cyc) begin
            total++;
            bad++;
            $display("FAIL sb_missing inst=%0d cyc=%0d got no dvalid want data=%h err=%b at cyc=%0d",
                     exp_q[i].id, cyc, exp_q[i].data, exp_q[i].err, exp_q[i].due);
            exp_q.delete(i);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      en  = 1'b0;
      clr = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic zero_model();
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < dep[k]; a++) ref_m[k][a] = '0;
   endtask

   // One accepted access: drive for a single cycle and push the model's results.
   task automatic acc(input logic w, input logic [3:0] b, input logic [7:0] a, input logic [31:0] d);
      logic [31:0] old_w, mrg;
      en = 1'b1; wen = w; be = b; addr = a; datai = d;
      for (int k = 0; k < NI; k++) begin
         if (int'(a) >= dep[k]) begin
            exp_q.push_back('{id: 3'(k), due: 32'(cyc + lat[k]), err: 1'b1, data: 32'h0});
         end else begin
            old_w = ref_m[k][a];
            mrg   = old_w;
            for (int i = 0; i < 4; i++) if (b[i]) mrg[i*8 +: 8] = d[i*8 +: 8];
            if (w) ref_m[k][a] = mrg;
            if (!w || mode[k] == 0)
               exp_q.push_back('{id: 3'(k), due: 32'(cyc + lat[k]), err: 1'b0, data: old_w});
            else if (mode[k] == 1)
               exp_q.push_back('{id: 3'(k), due: 32'(cyc + lat[k]), err: 1'b0, data: mrg});
         end
      end
      @(negedge clk);
      en = 1'b0;
   endtask

   // Called right after rst_n release at a negedge; counts busy cycles of the 256 and 200 deep parts.
   task automatic count_clear(input int pulse_at, output int c0, output int c4);
      c0 = 0;
      c4 = 0;
      for (int i = 0; i < 400; i++) begin
         clr = (i == pulse_at);
         @(negedge clk);
         if (busy_a[0]) c0++;
         if (busy_a[4]) c4++;
      end
      clr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int c0, c4;
      #12;
      total++;
      if (datao_a[0] !== 32'h0 || dvalid_a[0] !== 1'b0 || err_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
         bad++;
         $display("FAIL reset_outputs got datao=%h dvalid=%b err=%b busy=%b want 0 0 0 1",
                  datao_a[0], dvalid_a[0], err_a[0], busy_a[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      count_clear(100, c0, c4);
      total++;
      if (c0 !== 256 || c4 !== 200 || busy_a[0] !== 1'b0) begin
         bad++;
         $display("FAIL init_clear_len got %0d/%0d busy=%b want 256/200 busy=0", c0, c4, busy_a[0]);
      end
      zero_model();
      acc(1'b0, 4'h0, 8'h7F, 32'h0);
      idle(4);
      total++;
      if (datao_a[0] !== 32'h0) begin
         bad++;
         $display("FAIL init_read got %h want 00000000", datao_a[0]);
      end
   endtask

   task automatic test_byte_en();
      acc(1'b1, 4'b1111, 8'h10, 32'hDEADBEEF);
      acc(1'b1, 4'b0101, 8'h10, 32'h11223344);
      acc(1'b0, 4'b0000, 8'h10, 32'h0);
      idle(4);
      total++;
      if (datao_a[0] !== 32'hDE22BE44) begin
         bad++;
         $display("FAIL byte_en got %h want de22be44", datao_a[0]);
      end
      acc(1'b1, 4'b0000, 8'h10, 32'hFFFFFFFF);
      acc(1'b0, 4'b0000, 8'h10, 32'h0);
      idle(4);
      total++;
      if (datao_a[0] !== 32'hDE22BE44) begin
         bad++;
         $display("FAIL be_zero_noop got %h want de22be44", datao_a[0]);
      end
   endtask

   task automatic test_rdw();
      acc(1'b1, 4'hF, 8'h05, 32'hAAAAAAAA);
      idle(3);
      acc(1'b1, 4'hF, 8'h05, 32'h55555555);
      idle(4);
      total++;
      if (datao_a[0] !== 32'hAAAAAAAA || datao_a[3] !== 32'hAAAAAAAA) begin
         bad++;
         $display("FAIL rdw_read_first got %h/%h want aaaaaaaa", datao_a[0], datao_a[3]);
      end
      total++;
      if (datao_a[1] !== 32'h55555555) begin
         bad++;
         $display("FAIL rdw_write_first got %h want 55555555", datao_a[1]);
      end
      total++;
      if (datao_a[2] !== 32'hDE22BE44) begin
         bad++;
         $display("FAIL rdw_no_change_hold got %h want de22be44", datao_a[2]);
      end
   endtask

   task automatic test_rd_lat2();
      logic        v0, v1, v2;
      logic [31:0] d0, d1;
      acc(1'b1, 4'hF, 8'h01, 32'h01010101);
      acc(1'b1, 4'hF, 8'h02, 32'h02020202);
      acc(1'b1, 4'hF, 8'h03, 32'h03030303);
      idle(3);
      acc(1'b0, 4'h0, 8'h01, 32'h0);
      acc(1'b0, 4'h0, 8'h02, 32'h0);
      acc(1'b0, 4'h0, 8'h03, 32'h0);
      v0 = dvalid_a[3]; d0 = datao_a[3];
      @(negedge clk);
      v1 = dvalid_a[3]; d1 = datao_a[3];
      @(negedge clk);
      v2 = dvalid_a[3];
      total++;
      if ({v0, v1, v2} !== 3'b110 || d0 !== 32'h02020202 || d1 !== 32'h03030303) begin
         bad++;
         $display("FAIL rd_lat2_pipe got v=%b%b%b d=%h,%h want v=110 d=02020202,03030303",
                  v0, v1, v2, d0, d1);
      end
      idle(3);
   endtask

   task automatic test_range();
      acc(1'b1, 4'hF, 8'd50, 32'h50505050);
      acc(1'b1, 4'hF, 8'd250, 32'hCAFEF00D);
      total++;
      if (err_a[4] !== 1'b1 || dvalid_a[4] !== 1'b1 || datao_a[4] !== 32'h0 || err_a[0] !== 1'b0) begin
         bad++;
         $display("FAIL range_write got err=%b dv=%b d=%h err0=%b want 1 1 0 0",
                  err_a[4], dvalid_a[4], datao_a[4], err_a[0]);
      end
      acc(1'b0, 4'h0, 8'd250, 32'h0);
      total++;
      if (err_a[4] !== 1'b1 || datao_a[4] !== 32'h0 || datao_a[0] !== 32'hCAFEF00D) begin
         bad++;
         $display("FAIL range_read got err=%b d=%h d0=%h want 1 0 cafef00d",
                  err_a[4], datao_a[4], datao_a[0]);
      end
      acc(1'b0, 4'h0, 8'd50, 32'h0);
      total++;
      if (err_a[4] !== 1'b0 || datao_a[4] !== 32'h50505050) begin
         bad++;
         $display("FAIL range_no_alias got err=%b d=%h want 0 50505050", err_a[4], datao_a[4]);
      end
      idle(3);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++)
         acc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom);
      idle(4);
   endtask

   task automatic test_clear_reset();
      int c0, c4;
      acc(1'b1, 4'hF, 8'h03, 32'h12345678);
      acc(1'b0, 4'h0, 8'h03, 32'h0);
      idle(3);
      total++;
      if (datao_a[0] !== 32'h12345678) begin
         bad++;
         $display("FAIL hold_before_clr got %h want 12345678", datao_a[0]);
      end
      en = 1'b1; wen = 1'b0; addr = 8'h03; clr = 1'b1;
      @(negedge clk);
      en = 1'b0; clr = 1'b0;
      zero_model();
      total++;
      if (busy_a[0] !== 1'b1) begin
         bad++;
         $display("FAIL clr_start got busy=%b want 1", busy_a[0]);
      end
      en = 1'b1; wen = 1'b0; addr = 8'h03;
      repeat (5) @(negedge clk);
      en = 1'b0;
      total++;
      if (datao_a[0] !== 32'h12345678 || dvalid_a[0] !== 1'b0) begin
         bad++;
         $display("FAIL en_while_busy got d=%h dv=%b want 12345678 0", datao_a[0], dvalid_a[0]);
      end
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (datao_a[0] !== 32'h0 || datao_a[3] !== 32'h0 || dvalid_a[0] !== 1'b0 || err_a[0] !== 1'b0
          || busy_a[0] !== 1'b1) begin
         bad++;
         $display("FAIL mid_clear_reset got d=%h d3=%h dv=%b err=%b busy=%b want 0 0 0 0 1",
                  datao_a[0], datao_a[3], dvalid_a[0], err_a[0], busy_a[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      count_clear(-1, c0, c4);
      total++;
      if (c0 !== 256 || c4 !== 200) begin
         bad++;
         $display("FAIL clear_restart got %0d/%0d want 256/200", c0, c4);
      end
      acc(1'b0, 4'h0, 8'h00, 32'h0);
      acc(1'b0, 4'h0, 8'h03, 32'h0);
      acc(1'b0, 4'h0, 8'h7F, 32'h0);
      acc(1'b0, 4'h0, 8'd199, 32'h0);
      acc(1'b0, 4'h0, 8'd255, 32'h0);
      idle(4);
   endtask

   task automatic test_drain();
      idle(4);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_byte_en();
      test_rdw();
      test_rd_lat2();
      test_range();
      test_random();
      test_clear_reset();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
